// File: rtl/pipo_shift_seq.sv
// pipo_shift_seq: parallel-in/parallel-out shifter, STEP bits per clock,
// start/busy/done handshake. Revision 1.0
`default_nettype none

module pipo_shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             carry_out
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int CW = ((AMT_W > SW) ? AMT_W : SW) + 1;
  localparam logic [CW-1:0] STEP_C  = CW'(STEP);
  localparam logic [SW-1:0] WIDTH_C = SW'(WIDTH);

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;
  localparam logic [2:0] MODE_SL  = 3'd5;
  localparam logic [2:0] MODE_SR  = 3'd6;
  localparam logic [2:0] MODE_NOP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic [2:0]       op;

  logic [CW-1:0]    rem_ext;
  logic [CW-1:0]    s_ext;
  logic [SW-1:0]    s;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] fill_lo, fill_hi;
  logic [WIDTH-1:0] lsl_v, lsr_v, asr_v;
  logic [WIDTH:0]   left_ext, right_ext;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_carry;

  always_comb begin
    rem_ext  = CW'(rem);
    s_ext    = (rem_ext < STEP_C) ? rem_ext : STEP_C;
    s        = SW'(s_ext);
    rem_next = rem - AMT_W'(s_ext);

    fill_lo  = ~({WIDTH{1'b1}} << s);
    fill_hi  = ~({WIDTH{1'b1}} >> s);
    lsl_v    = data_out << s;
    lsr_v    = data_out >> s;
    asr_v    = $signed(data_out) >>> s;

    // One extra bit on each side captures the last bit pushed out
    left_ext  = {1'b0, data_out} << s;
    right_ext = {data_out, 1'b0} >> s;

    nxt_data  = data_out;
    nxt_carry = carry_out;
    case (op)
      MODE_LSL: begin nxt_data = lsl_v;                                 nxt_carry = left_ext[WIDTH]; end
      MODE_LSR: begin nxt_data = lsr_v;                                 nxt_carry = right_ext[0];    end
      MODE_ASR: begin nxt_data = asr_v;                                 nxt_carry = right_ext[0];    end
      MODE_ROL: begin nxt_data = lsl_v | (data_out >> (WIDTH_C - s));   nxt_carry = left_ext[WIDTH]; end
      MODE_ROR: begin nxt_data = lsr_v | (data_out << (WIDTH_C - s));   nxt_carry = right_ext[0];    end
      MODE_SL:  begin nxt_data = lsl_v | (serial_in ? fill_lo : '0);    nxt_carry = left_ext[WIDTH]; end
      MODE_SR:  begin nxt_data = lsr_v | (serial_in ? fill_hi : '0);    nxt_carry = right_ext[0];    end
      default:  begin nxt_data = data_out;                              nxt_carry = carry_out;       end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      rem       <= '0;
      op        <= MODE_LSL;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (load) data_out <= data_in;
          if (start) begin
            op  <= mode;
            rem <= amount;
            if (amount == '0 || mode == MODE_NOP) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          data_out  <= nxt_data;
          carry_out <= nxt_carry;
          rem       <= rem_next;
          if (rem_next == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipo_shift_seq.sv
// tb_pipo_shift_seq: STEP=1 and STEP=4 instances share stimulus; a bit-serial
// reference model feeds per-instance scoreboards checked on each done pulse.
`default_nettype none

module tb_pipo_shift_seq;

  logic        clk = 1'b0;
  logic        reset, load, start, serial_in;
  logic [15:0] data_in;
  logic [2:0]  mode;
  logic [4:0]  amount;
  logic [15:0] dout [2];
  logic        busy [2];
  logic        done [2];
  logic        cout [2];

  always #5 clk = ~clk;

  pipo_shift_seq #(.WIDTH(16), .AMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .start(start),
    .mode(mode), .amount(amount), .serial_in(serial_in),
    .data_out(dout[0]), .busy(busy[0]), .done(done[0]), .carry_out(cout[0]));

  pipo_shift_seq #(.WIDTH(16), .AMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .start(start),
    .mode(mode), .amount(amount), .serial_in(serial_in),
    .data_out(dout[1]), .busy(busy[1]), .done(done[1]), .carry_out(cout[1]));

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdata  = 16'h0000;
  logic        mcarry = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: apply the operation one bit position at a time
  function automatic void model(input logic [2:0] m, input int amt, input logic sin);
    for (int k = 0; k < amt && m != 3'd7; k++) begin
      case (m)
        3'd0: begin mcarry = mdata[15]; mdata = {mdata[14:0], 1'b0};     end
        3'd1: begin mcarry = mdata[0];  mdata = {1'b0, mdata[15:1]};     end
        3'd2: begin mcarry = mdata[0];  mdata = {mdata[15], mdata[15:1]}; end
        3'd3: begin mcarry = mdata[15]; mdata = {mdata[14:0], mdata[15]}; end
        3'd4: begin mcarry = mdata[0];  mdata = {mdata[0], mdata[15:1]};  end
        3'd5: begin mcarry = mdata[15]; mdata = {mdata[14:0], sin};      end
        default: begin mcarry = mdata[0]; mdata = {sin, mdata[15:1]};    end
      endcase
    end
  endfunction

  // Monitor: pops the expected result whenever an instance pulses done
  int   bcnt  [2] = '{0, 0};
  logic pdone [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        bcnt[i] = 0;
      end else begin
        if (busy[i]) bcnt[i]++;
        if (done[i]) begin
          if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: inst %0d pulsed done with no pending op", i);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("data_inst%0d", i),      dout[i], e.d);
            chk($sformatf("carry_inst%0d", i),     cout[i], e.c);
            chk($sformatf("busy_cycles_inst%0d", i), bcnt[i], e.cyc);
            chk($sformatf("busy_at_done_inst%0d", i), busy[i], 0);
            chk($sformatf("done_prev_low_inst%0d", i), pdone[i], 0);
          end
          bcnt[i] = 0;
        end
      end
      pdone[i] = done[i];
    end
  end

  // Call at a negedge with both instances idle; returns at a negedge with both idle
  task automatic do_op(input bit ld, input logic [15:0] din, input logic [2:0] m,
                       input logic [4:0] amt, input logic sin);
    exp_t e;
    int   guard;
    load = ld; data_in = din; start = 1'b1; mode = m; amount = amt; serial_in = sin;
    if (ld) mdata = din;
    model(m, int'(amt), sin);
    e.d = mdata;
    e.c = mcarry;
    e.cyc = (m == 3'd7 || amt == 0) ? 0 : int'(amt);
    q0.push_back(e);
    e.cyc = (m == 3'd7 || amt == 0) ? 0 : (int'(amt) + 3) / 4;
    q1.push_back(e);
    guard = 0;
    do begin
      @(negedge clk);
      // Junk on load/start/mode/amount while both are shifting must be ignored
      if (busy[0] && busy[1]) begin
        load = 1'($urandom); data_in = 16'($urandom); start = 1'($urandom);
        mode = 3'($urandom); amount = 5'($urandom);
      end else begin
        load = 1'b0; start = 1'b0;
      end
      guard++;
    end while ((q0.size() != 0 || q1.size() != 0) && guard < 400);
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL timeout: op mode %0d amount %0d never completed", m, amt);
      q0.delete();
      q1.delete();
    end
    load = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] din);
    load = 1'b1; data_in = din;
    @(negedge clk);
    load = 1'b0;
    mdata = din;
    chk("load_inst0", dout[0], din);
    chk("load_inst1", dout[1], din);
    chk("load_carry_kept", cout[0], mcarry);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; serial_in = 1'b0;
    data_in = '0; mode = '0; amount = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_data%0d", i),  dout[i], 0);
      chk($sformatf("rst_busy%0d", i),  busy[i], 0);
      chk($sformatf("rst_done%0d", i),  done[i], 0);
      chk($sformatf("rst_carry%0d", i), cout[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    do_load(16'h8E16); do_op(0, 16'h0, 3'd0, 5'd3, 0);
    chk("lsl3_data", dout[0], 16'h70B0); chk("lsl3_carry", cout[0], 0);
    do_load(16'h8E16); do_op(0, 16'h0, 3'd2, 5'd4, 0);
    chk("asr4_data", dout[0], 16'hF8E1); chk("asr4_carry", cout[1], 0);
    do_load(16'h8E16); do_op(0, 16'h0, 3'd4, 5'd8, 0);
    chk("ror8_data", dout[1], 16'h168E);
    do_load(16'h8E16); do_op(0, 16'h0, 3'd3, 5'd20, 0);
    chk("rol20_s1", dout[0], 16'hE168); chk("rol20_s4", dout[1], 16'hE168);
    do_load(16'h8E16); do_op(0, 16'h0, 3'd0, 5'd0, 0);
    chk("amt0_hold", dout[0], 16'h8E16);
    do_op(0, 16'h0, 3'd7, 5'd9, 0);
    chk("nop_hold", dout[1], 16'h8E16);
    do_op(0, 16'h0, 3'd5, 5'd4, 1);
    chk("sl4_fill1", dout[0], 16'hE16F);
    do_op(1, 16'h8E16, 3'd1, 5'd31, 0);
    chk("lsr31_zero", dout[1], 16'h0000);

    // Reset during the second shift cycle
    do_load(16'h8E16);
    start = 1'b1; mode = 3'd0; amount = 5'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q0.delete(); q1.delete();
    mdata = 16'h0000; mcarry = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_data%0d", i),  dout[i], 0);
      chk($sformatf("midrst_busy%0d", i),  busy[i], 0);
      chk($sformatf("midrst_done%0d", i),  done[i], 0);
      chk($sformatf("midrst_carry%0d", i), cout[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    do_op(1, 16'h8E16, 3'd3, 5'd20, 0);
    chk("post_rst_rol20", dout[0], 16'hE168);

    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
